coin_acceptor: RTL and testbench

// - Front-end stage feeding the vending FSM's 2-bit coin input from raw coin-slot sensors and a cancel button.
// - Synchronises and debounces the inputs, then classifies each coin event.
// - Emits exactly one single-cycle coin code per valid event.
// - Returns invalid coins, or coins arriving while acceptance is disabled, via coin_return.
// - Flags jammed sensors.

---
 rtl/vend_pkg.sv | 46 ++++
 rtl/coin_sync.sv | 31 +++
 rtl/coin_acceptor.sv | 137 +++++++++++++
 tb/tb_coin_acceptor.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending front end: coin codes, acceptor state
// encoding, sensor pattern bit positions and the EMIT classification rule.
package vend_pkg;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_5      = 2'b01;
    localparam logic [1:0] COIN_10     = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUAL    = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam int PAT_W    = 3;
    localparam int P_5      = 0;
    localparam int P_10     = 1;
    localparam int P_CANCEL = 2;

    typedef struct packed {
        logic       ret;
        logic [1:0] code;
    } emit_t;

    // Multi-hot patterns are always returned, never reported as cancel,
    // so a coin landing together with the button cannot wipe the credit.
    function automatic emit_t classify(input logic [PAT_W-1:0] pat, input logic en);
        emit_t r;
        r.code = COIN_NONE;
        r.ret  = 1'b0;
        case (pat)
            3'b001: begin
                if (en) r.code = COIN_5;
                else    r.ret  = 1'b1;
            end
            3'b010: begin
                if (en) r.code = COIN_10;
                else    r.ret  = 1'b1;
            end
            3'b100:  r.code = COIN_CANCEL;
            default: r.ret  = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchroniser per bit for the asynchronous slot sensors and button.
module coin_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (!reset) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: debounces the synchronised sensor pattern, classifies
// each qualified event into a one-cycle coin code or return, and flags jams.
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int JAM_CYC      = 1000,
    parameter int CNT_W        = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sense_5,
    input  logic       sense_10,
    input  logic       cancel,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       coin_return,
    output logic       jam,
    output logic       busy
);

    // DEBOUNCE_CYC must be at least 2: the IDLE sample counts as the first.
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] DEB_FULL = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] JAM_MAX  = CNT_W'(JAM_CYC);

    logic [PAT_W-1:0] raw;
    logic [PAT_W-1:0] pat;

    assign raw[P_5]      = sense_5;
    assign raw[P_10]     = sense_10;
    assign raw[P_CANCEL] = cancel;

    coin_sync #(
        .WIDTH (PAT_W)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw),
        .q     (pat)
    );

    logic [1:0]       state_reg, state_next;
    logic [PAT_W-1:0] cand_reg, cand_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] hold_reg, hold_next;
    logic [1:0]       coin_reg, coin_next;
    logic             ret_reg, ret_next;
    logic             jam_reg, jam_next;
    logic [CNT_W-1:0] cnt_inc;
    emit_t            result;

    assign cnt_inc = cnt_reg + CNT_W'(1);
    assign result  = classify(cand_reg, accept_en);

    always_comb begin
        state_next = state_reg;
        cand_next  = cand_reg;
        cnt_next   = cnt_reg;
        hold_next  = hold_reg;
        coin_next  = COIN_NONE;
        ret_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pat != '0) begin
                    state_next = ST_QUAL;
                    cand_next  = pat;
                    cnt_next   = '0;
                end
            end
            ST_QUAL: begin
                if (pat == '0) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (pat != cand_reg) begin
                    cand_next = pat;
                    cnt_next  = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    state_next = ST_EMIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_EMIT: begin
                coin_next  = result.code;
                ret_next   = result.ret;
                state_next = ST_RELEASE;
                cnt_next   = '0;
                hold_next  = '0;
            end
            default: begin
                // RELEASE: any activity restarts the quiet-time count.
                if (pat == '0) begin
                    if (cnt_inc == DEB_FULL) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    cnt_next = '0;
                    if (hold_reg != JAM_MAX) begin
                        hold_next = hold_reg + CNT_W'(1);
                    end
                end
            end
        endcase
        jam_next = (state_next == ST_RELEASE) && (hold_next == JAM_MAX);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cand_reg  <= '0;
            cnt_reg   <= '0;
            hold_reg  <= '0;
            coin_reg  <= COIN_NONE;
            ret_reg   <= 1'b0;
            jam_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cand_reg  <= cand_next;
            cnt_reg   <= cnt_next;
            hold_reg  <= hold_next;
            coin_reg  <= coin_next;
            ret_reg   <= ret_next;
            jam_reg   <= jam_next;
        end
    end

    assign coin        = coin_reg;
    assign coin_return = ret_reg;
    assign jam         = jam_reg;
    assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised coin events checked cycle by cycle against an event-level timing
// model derived from the debounce, emit and release rules.
module tb_coin_acceptor;

    localparam int D   = 4;
    localparam int JAM = 1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       sense_5, sense_10, cancel, accept_en;
    logic [1:0] coin;
    logic       coin_return, jam, busy;

    int n_checks = 0;
    int n_fail   = 0;

    coin_acceptor #(
        .DEBOUNCE_CYC (D),
        .JAM_CYC      (JAM),
        .CNT_W        (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sense_5     (sense_5),
        .sense_10    (sense_10),
        .cancel      (cancel),
        .accept_en   (accept_en),
        .coin        (coin),
        .coin_return (coin_return),
        .jam         (jam),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_pat(input logic [2:0] p);
        {cancel, sense_10, sense_5} = p;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".coin"}, 32'(coin), 32'd0);
        check_eq({tag, ".ret"},  32'(coin_return), 32'd0);
        check_eq({tag, ".jam"},  32'(jam), 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    // Raw pattern pat applied for len cycles; every cycle of the event is checked.
    // The FSM sees the pattern on edges 3..len+2 (two-flop synchroniser).
    task automatic run_txn(input logic [2:0] pat, input int len, input logic en, input int gap);
        int emit_at, idle_at, jam_on, total, nz_end;
        logic [1:0] exp_code;
        logic       exp_ret;
        logic       exp_jam;
        nz_end = len + 2;
        if (len < D) begin
            emit_at = -1;
            idle_at = nz_end + 1;
        end else begin
            emit_at = D + 2;
            idle_at = ((nz_end > D + 3) ? nz_end : D + 3) + D;
        end
        jam_on = D + 3 + JAM;
        exp_code = 2'b00;
        exp_ret  = 1'b0;
        if (emit_at > 0) begin
            if (pat == 3'b100)                          exp_code = 2'b11;
            else if (pat == 3'b001 && en)               exp_code = 2'b01;
            else if (pat == 3'b010 && en)               exp_code = 2'b10;
            else                                        exp_ret  = 1'b1;
        end
        total = idle_at + 3 + gap;
        $display("txn pat=%b len=%0d en=%0d -> code=%b ret=%0d jam=%0d", pat, len, en,
                 exp_code, exp_ret, (emit_at > 0 && nz_end >= jam_on));
        @(posedge clk);
        #1;
        accept_en = en;
        set_pat(pat);
        for (int j = 1; j <= total; j++) begin
            @(posedge clk);
            #1;
            check_eq("coin", 32'(coin), (emit_at > 0 && j == emit_at + 1) ? 32'(exp_code) : 32'd0);
            check_eq("ret", 32'(coin_return), (emit_at > 0 && j == emit_at + 1) ? 32'(exp_ret) : 32'd0);
            check_eq("busy", 32'(busy), (j >= 3 && j < idle_at) ? 32'd1 : 32'd0);
            exp_jam = (emit_at > 0) && (nz_end >= jam_on) && (j >= jam_on) && (j < idle_at);
            check_eq("jam", 32'(jam), 32'(exp_jam));
            if (j == len) set_pat(3'b000);
        end
    endtask

    initial begin
        reset     = 1'b0;
        accept_en = 1'b1;
        set_pat(3'b001);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_quiet("reset");
        end
        set_pat(3'b000);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_quiet("post_reset");
        end

        run_txn(3'b001, 10, 1'b1, 2);
        run_txn(3'b010, 10, 1'b1, 2);
        run_txn(3'b010, 3,  1'b1, 2);
        run_txn(3'b001, 4,  1'b1, 0);
        run_txn(3'b011, 8,  1'b1, 1);
        run_txn(3'b001, 6,  1'b0, 1);
        run_txn(3'b100, 6,  1'b0, 1);
        run_txn(3'b001, 1100, 1'b1, 2);
        run_txn(3'b001, 10, 1'b1, 2);

        // Reset while qualifying: the event is dropped without a pulse.
        @(posedge clk);
        #1;
        set_pat(3'b001);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            #1;
        end
        check_eq("midqual.busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        set_pat(3'b000);
        @(posedge clk);
        #1;
        check_quiet("midqual.reset");
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_quiet("midqual.after");
        end

        for (int t = 0; t < 30; t++) begin
            run_txn(3'($urandom_range(1, 7)), int'($urandom_range(1, 14)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
